// File: rtl/switch_pkg.sv
// Shared helpers for the input-buffered switch: flit geometry and port-index width.
// A flit is {tail, addr, data}, packed MSB to LSB.
package switch_pkg;

   // Total flit width for a given payload and address size.
   function automatic int bus_size(input int data_size, input int addr_size);
      return data_size + addr_size + 1;
   endfunction

   // Bit offset of the payload field.
   function automatic int data_lsb();
      return 0;
   endfunction

   // Bit offset of the destination-address field.
   function automatic int addr_lsb(input int data_size);
      return data_size;
   endfunction

   // Bit position of the tail flag.
   function automatic int tail_bit(input int data_size, input int addr_size);
      return data_size + addr_size;
   endfunction

   // Bits needed to hold a port index in 0..ports-1.
   function automatic int port_w(input int ports);
      return (ports <= 2) ? 1 : $clog2(ports);
   endfunction

endpackage

// File: rtl/queue.sv
// Synchronous FIFO with 2**PTR_SIZE entries and a combinational head read.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module queue #(
   parameter int BUS_SIZE = 37,
   parameter int PTR_SIZE = 3
) (
   input  logic                clk,
   input  logic                a_rst,
   input  logic                push,
   input  logic                pop,
   input  logic [BUS_SIZE-1:0] din,
   output logic [BUS_SIZE-1:0] dout,
   output logic                full,
   output logic                empty
);
   localparam int DEPTH = 2 ** PTR_SIZE;

   logic [BUS_SIZE-1:0] mem [DEPTH];
   logic [PTR_SIZE:0]   wr_ptr;
   logic [PTR_SIZE:0]   rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_SIZE] != rd_ptr[PTR_SIZE]) &&
                  (wr_ptr[PTR_SIZE-1:0] == rd_ptr[PTR_SIZE-1:0]);
   assign dout  = mem[rd_ptr[PTR_SIZE-1:0]];

   // Advance the pointers on accepted pushes and pops.
   // NOTE: state registers use <= so every block samples pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
         if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Write storage.
   // NOTE: storage has no reset; the pointers make stale entries unreachable, and this keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[PTR_SIZE-1:0]] <= din;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: one-hot grant to the first requester at or after ptr, cyclically.
module rr_arbiter
   import switch_pkg::*;
#(
   parameter int N = 5,
   parameter int W = port_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt
);
   // Scan from ptr, wrapping, and keep the first hit.
   // NOTE: every variable gets a value before any branch, so no path can infer a latch.
   always_comb begin
      logic         found;
      logic [W-1:0] idx;
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = W'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_ib.sv
// Input-buffered NoC switch: a FIFO per input, table routing, a round-robin
// arbiter and output register per output, optional wormhole locking.
// RT_TABLE packs the routing ROM: entry n (output port for destination n) at [n*PW +: PW].
module switch_ib
   import switch_pkg::*;
#(
   parameter int DATA_SIZE   = 32,
   parameter int ADDR_SIZE   = 4,
   parameter int PORTS_NUM   = 4,
   parameter int NODES_NUM   = 9,
   parameter int ADDR        = 0,
   parameter int MEM_LOG2    = 3,
   parameter logic [NODES_NUM*port_w(PORTS_NUM+1)-1:0] RT_TABLE = '0,
   parameter int PACKET_MODE = 0,
   localparam int BUS_SIZE   = bus_size(DATA_SIZE, ADDR_SIZE)
) (
   input  logic                             clk,
   input  logic                             a_rst,
   input  logic [PORTS_NUM:0]               wr_ready_in,
   output logic [PORTS_NUM:0]               r_ready_out,
   input  logic [BUS_SIZE*(PORTS_NUM+1)-1:0] data_i,
   output logic [PORTS_NUM:0]               wr_ready_out,
   input  logic [PORTS_NUM:0]               r_ready_in,
   output logic [BUS_SIZE*(PORTS_NUM+1)-1:0] data_o,
   output logic                             drop_o
);
   localparam int NP    = PORTS_NUM + 1;
   localparam int PW    = port_w(NP);
   localparam int A_LSB = addr_lsb(DATA_SIZE);
   localparam int T_BIT = tail_bit(DATA_SIZE, ADDR_SIZE);

   logic [NP-1:0]       full, empty, push, pop, drop_req, routable, can_load;
   logic [BUS_SIZE-1:0] head     [NP];
   logic [PW-1:0]       route    [NP];
   logic [PW-1:0]       rt       [2**ADDR_SIZE];
   logic [NP-1:0]       req      [NP];
   logic [NP-1:0]       arb_gnt  [NP];
   logic [NP-1:0]       gnt      [NP];
   logic [PW-1:0]       win      [NP];
   logic [PW-1:0]       ptr      [NP];
   logic [PW-1:0]       lock_src [NP];
   logic [NP-1:0]       locked;
   logic [NP-1:0]       out_valid;
   logic [BUS_SIZE-1:0] out_data [NP];

   assign push        = wr_ready_in & ~full;
   assign r_ready_out = ~full;
   assign wr_ready_out = out_valid;

   for (genvar n = 0; n < 2**ADDR_SIZE; n++) begin : g_rt
      if (n < NODES_NUM) begin : g_used
         assign rt[n] = RT_TABLE[n*PW +: PW];
      end else begin : g_unused
         assign rt[n] = '0;
      end
   end

   for (genvar p = 0; p < NP; p++) begin : g_in
      queue #(.BUS_SIZE(BUS_SIZE), .PTR_SIZE(MEM_LOG2)) u_queue (
         .clk  (clk),
         .a_rst(a_rst),
         .push (push[p]),
         .pop  (pop[p]),
         .din  (data_i[p*BUS_SIZE +: BUS_SIZE]),
         .dout (head[p]),
         .full (full[p]),
         .empty(empty[p])
      );
      assign data_o[p*BUS_SIZE +: BUS_SIZE] = out_data[p];
   end

   for (genvar o = 0; o < NP; o++) begin : g_arb
      rr_arbiter #(.N(NP), .W(PW)) u_arb (
         .req(req[o]),
         .ptr(ptr[o]),
         .gnt(arb_gnt[o])
      );
   end

   // Decode each head flit's destination into an output port, or flag it unroutable.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         route[p]    = rt[head[p][A_LSB +: ADDR_SIZE]];
         routable[p] = 1'b1;
         if (head[p][A_LSB +: ADDR_SIZE] == ADDR_SIZE'(ADDR))
            route[p] = PW'(PORTS_NUM);
         else if (int'(head[p][A_LSB +: ADDR_SIZE]) >= NODES_NUM)
            routable[p] = 1'b0;
         drop_req[p] = !empty[p] && !routable[p];
      end
   end

   // Build per-output request vectors, qualify grants by output space, and derive pops.
   always_comb begin
      pop = drop_req;
      for (int o = 0; o < NP; o++) begin
         can_load[o] = !out_valid[o] || r_ready_in[o];
         win[o]      = '0;
         for (int p = 0; p < NP; p++) begin
            req[o][p] = !empty[p] && routable[p] && (route[p] == PW'(o)) &&
                        (!locked[o] || (lock_src[o] == PW'(p)));
            if (arb_gnt[o][p]) win[o] = PW'(p);
         end
         gnt[o] = arb_gnt[o] & {NP{can_load[o]}};
         pop    = pop | gnt[o];
      end
   end

   // Output registers, round-robin pointers, wormhole locks and the drop pulse.
   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         drop_o    <= 1'b0;
         out_valid <= '0;
         locked    <= '0;
         for (int o = 0; o < NP; o++) begin
            out_data[o] <= '0;
            ptr[o]      <= '0;
            lock_src[o] <= '0;
         end
      end else begin
         drop_o <= |drop_req;
         for (int o = 0; o < NP; o++) begin
            if (|gnt[o]) begin
               out_valid[o] <= 1'b1;
               out_data[o]  <= head[win[o]];
               if (PACKET_MODE == 0 || head[win[o]][T_BIT])
                  ptr[o] <= (win[o] == PW'(PORTS_NUM)) ? '0 : win[o] + 1'b1;
               if (PACKET_MODE != 0) begin
                  if (head[win[o]][T_BIT]) begin
                     locked[o] <= 1'b0;
                  end else begin
                     locked[o]   <= 1'b1;
                     lock_src[o] <= win[o];
                  end
               end
            end else if (r_ready_in[o]) begin
               out_valid[o] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_ib.sv
// Bench for switch_ib: directed scenarios plus randomized traffic scored
// against a per-(source, output) ordering model. Instance 0 arbitrates per
// flit, instance 1 uses wormhole locking.
`timescale 1ns/1ps
module tb_switch_ib;
   localparam int NP = 5;
   localparam int BS = 37;
   localparam int PW = 3;
   localparam int NODES = 9;
   localparam int RT_MAP [NODES] = '{0, 0, 1, 2, 3, 3, 1, 0, 2};

   function automatic logic [NODES*PW-1:0] pack_rt();
      logic [NODES*PW-1:0] v;
      v = '0;
      for (int n = 0; n < NODES; n++) v[n*PW +: PW] = PW'(RT_MAP[n]);
      return v;
   endfunction
   localparam logic [NODES*PW-1:0] RT = pack_rt();

   logic            clk = 1'b0;
   logic            a_rst = 1'b0;
   logic [NP-1:0]   wr_in [2];
   logic [NP-1:0]   rdy_out [2];
   logic [NP-1:0]   wr_out [2];
   logic [NP-1:0]   rin [2];
   logic [BS*NP-1:0] din [2];
   logic [BS*NP-1:0] dout [2];
   logic            drop [2];

   always #5 clk = ~clk;

   switch_ib #(.RT_TABLE(RT), .PACKET_MODE(0)) dut0 (
      .clk(clk), .a_rst(a_rst), .wr_ready_in(wr_in[0]), .r_ready_out(rdy_out[0]),
      .data_i(din[0]), .wr_ready_out(wr_out[0]), .r_ready_in(rin[0]),
      .data_o(dout[0]), .drop_o(drop[0]));

   switch_ib #(.RT_TABLE(RT), .PACKET_MODE(1)) dut1 (
      .clk(clk), .a_rst(a_rst), .wr_ready_in(wr_in[1]), .r_ready_out(rdy_out[1]),
      .data_i(din[1]), .wr_ready_out(wr_out[1]), .r_ready_in(rin[1]),
      .data_o(dout[1]), .drop_o(drop[1]));

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [BS-1:0] mk(input logic tail, input logic [3:0] d, input logic [31:0] data);
      return {tail, d, data};
   endfunction

   // Destination -> output port, or -1 when the flit must be dropped.
   function automatic int route_of(input logic [3:0] d);
      if (d == 4'd0) return 4;
      if (int'(d) < NODES) return RT_MAP[int'(d)];
      return -1;
   endfunction

   // Scoreboard: expected flits per (instance, source, output), delivery log per (instance, output).
   logic [BS-1:0] exp_q [2*NP*NP][$];
   logic [BS-1:0] log_flit [2*NP][$];
   int            log_cyc [2*NP][$];
   int            log_src [2*NP][$];
   int            exp_drops [2];
   int            obs_drops [2];
   int            lock_m [NP];

   always @(posedge clk) cyc <= cyc + 1;

   // Sample mid-cycle: what transfers on the coming edge.
   always @(negedge clk) begin : monitor
      logic [BS-1:0] f;
      int src, r, k;
      if (!a_rst) begin
         for (int q = 0; q < 2*NP*NP; q++) exp_q[q].delete();
         for (int o = 0; o < NP; o++) lock_m[o] = -1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (drop[i]) obs_drops[i]++;
            for (int o = 0; o < NP; o++) begin
               if (wr_out[i][o] && rin[i][o]) begin
                  f = dout[i][o*BS +: BS];
                  src = -1;
                  for (int s = 0; s < NP; s++) begin
                     k = i*NP*NP + s*NP + o;
                     if (src < 0 && exp_q[k].size() > 0 && exp_q[k][0] == f) src = s;
                  end
                  check("deliver_in_order", (src >= 0) ? 1 : 0, 1);
                  if (src >= 0) void'(exp_q[i*NP*NP + src*NP + o].pop_front());
                  if (i == 1) begin
                     if (lock_m[o] >= 0) check("wormhole_contig", src, lock_m[o]);
                     lock_m[o] = f[36] ? -1 : src;
                  end
                  log_flit[i*NP+o].push_back(f);
                  log_cyc[i*NP+o].push_back(cyc);
                  log_src[i*NP+o].push_back(src);
               end
            end
            for (int p = 0; p < NP; p++) begin
               if (wr_in[i][p] && rdy_out[i][p]) begin
                  f = din[i][p*BS +: BS];
                  r = route_of(f[35:32]);
                  if (r < 0) exp_drops[i]++;
                  else exp_q[i*NP*NP + p*NP + r].push_back(f);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log(input int idx);
      log_flit[idx].delete();
      log_cyc[idx].delete();
      log_src[idx].delete();
   endtask

   task automatic wait_log(input int idx, input int n, input int budget);
      int g;
      g = 0;
      while (log_flit[idx].size() < n && g < budget) begin
         tick();
         g++;
      end
   endtask

   task automatic send(input int i, input int p, input logic [BS-1:0] f);
      int g;
      logic ok;
      din[i][p*BS +: BS] = f;
      wr_in[i][p] = 1'b1;
      g = 0;
      do begin
         ok = rdy_out[i][p];
         tick();
         g++;
      end while (!ok && g < 50);
      wr_in[i][p] = 1'b0;
      check("send_accepted", ok, 1);
   endtask

   logic [NP-1:0] acc [2];
   bit            in_pkt [2][NP];
   logic [3:0]    pkt_dest [2][NP];

   initial begin : stim
      int acc_cnt, full_at, n;
      logic [NP-1:0] seen;
      logic tl;
      logic [3:0] d;
      for (int i = 0; i < 2; i++) begin
         wr_in[i] = '0; din[i] = '0; rin[i] = '1;
         exp_drops[i] = 0; obs_drops[i] = 0;
      end

      // Reset state
      repeat (3) tick();
      check("rst_wr_ready_out", wr_out[0], 0);
      check("rst_drop", drop[0], 0);
      check("rst_data_o", dout[0], 0);
      a_rst = 1'b1;
      tick();
      check("rst_r_ready_out", rdy_out[0], 5'h1f);

      // Reset mid-stream with three flits held
      rin[0][3] = 1'b0;
      for (int k = 0; k < 3; k++) send(0, 0, mk(1'b1, 4'd4, 32'hA0 + k));
      a_rst = 1'b0;
      tick();
      check("midrst_wr_ready_out", wr_out[0], 0);
      check("midrst_drop", drop[0], 0);
      a_rst = 1'b1;
      tick();
      check("midrst_r_ready_out", rdy_out[0], 5'h1f);
      rin[0][3] = 1'b1;
      seen = '0;
      for (int k = 0; k < 6; k++) begin
         seen |= wr_out[0];
         tick();
      end
      check("midrst_no_stale", seen, 0);

      // Local delivery, 1-cycle latency
      clear_log(4);
      din[0][1*BS +: BS] = mk(1'b1, 4'd0, 32'hDEADBEEF);
      wr_in[0][1] = 1'b1;
      tick();
      wr_in[0][1] = 1'b0;
      check("local_not_early", wr_out[0][4], 0);
      tick();
      check("local_valid", wr_out[0][4], 1);
      check("local_data", dout[0][4*BS +: BS], mk(1'b1, 4'd0, 32'hDEADBEEF));

      // Contention: ports 0,1,2 -> output 3
      clear_log(3);
      for (int k = 0; k < 4; k++) begin
         for (int p = 0; p < 3; p++) begin
            din[0][p*BS +: BS] = mk(1'b1, 4'd4, 32'(p*256 + k));
            wr_in[0][p] = 1'b1;
         end
         tick();
      end
      wr_in[0] = '0;
      wait_log(3, 12, 40);
      check("cont_count", log_flit[3].size(), 12);
      for (int j = 0; j < 12 && j < log_flit[3].size(); j++) begin
         check("cont_order", log_flit[3][j][31:0], (j % 3) * 256 + j / 3);
         check("cont_cycle", log_cyc[3][j] - log_cyc[3][0], j);
      end

      // Backpressure on output 3, port 0 streaming
      clear_log(3);
      rin[0][3] = 1'b0;
      acc_cnt = 0;
      full_at = -1;
      wr_in[0][0] = 1'b1;
      for (int t = 0; t < 40; t++) begin
         din[0][0*BS +: BS] = mk(1'b1, 4'd4, 32'h400 + acc_cnt);
         if (!rdy_out[0][0] && full_at < 0) full_at = acc_cnt;
         if (rdy_out[0][0]) acc_cnt++;
         tick();
      end
      wr_in[0][0] = 1'b0;
      check("bp_full_after", full_at, 9);
      check("bp_r_ready_low", rdy_out[0][0], 0);
      check("bp_held_valid", wr_out[0][3], 1);
      check("bp_held_data", dout[0][3*BS +: BS], mk(1'b1, 4'd4, 32'h400));
      check("bp_nothing_left", log_flit[3].size(), 0);
      rin[0][3] = 1'b1;
      wait_log(3, 9, 40);
      check("bp_count", log_flit[3].size(), 9);
      for (int j = 0; j < 9 && j < log_flit[3].size(); j++)
         check("bp_order", log_flit[3][j][31:0], 32'h400 + j);

      // Unroutable head dropped, follower forwarded
      clear_log(1);
      n = obs_drops[0];
      send(0, 2, mk(1'b1, 4'hF, 32'h11));
      send(0, 2, mk(1'b1, 4'd2, 32'h22));
      repeat (6) tick();
      check("drop_pulses", obs_drops[0] - n, 1);
      check("drop_follow_count", log_flit[1].size(), 1);
      if (log_flit[1].size() > 0) check("drop_follow_data", log_flit[1][0][31:0], 32'h22);

      // Wormhole: ports 0 and 2 send 3-flit packets to output 1
      clear_log(NP + 1);
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < 3; p += 2) begin
            din[1][p*BS +: BS] = mk(k == 2, 4'd2, 32'(p*256 + k));
            wr_in[1][p] = 1'b1;
         end
         tick();
      end
      wr_in[1] = '0;
      wait_log(NP + 1, 6, 40);
      check("pkt_count", log_flit[NP+1].size(), 6);
      for (int j = 0; j < 6 && j < log_flit[NP+1].size(); j++)
         check("pkt_order", log_flit[NP+1][j][31:0], (j / 3) * 512 + j % 3);

      // Randomized traffic on both instances
      for (int i = 0; i < 2; i++)
         for (int p = 0; p < NP; p++) in_pkt[i][p] = 1'b0;
      for (int t = 0; t < 2300; t++) begin
         for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < NP; p++) begin
               if (!wr_in[i][p] && (in_pkt[i][p] || (t < 2000 && $urandom_range(1) == 1))) begin
                  if (in_pkt[i][p]) begin
                     d = pkt_dest[i][p];
                     tl = (t >= 2000) || ($urandom_range(2) == 0);
                  end else if (p == 2 && $urandom_range(7) == 0) begin
                     d = 4'hF;
                     tl = 1'b1;
                  end else begin
                     d = 4'($urandom_range(8));
                     tl = (t >= 2000) || ($urandom_range(2) == 0);
                  end
                  in_pkt[i][p] = !tl;
                  pkt_dest[i][p] = d;
                  din[i][p*BS +: BS] = mk(tl, d, $urandom);
                  wr_in[i][p] = 1'b1;
               end
            end
            for (int o = 0; o < NP; o++)
               rin[i][o] = (t >= 2000) || ($urandom_range(3) != 0);
            acc[i] = wr_in[i] & rdy_out[i];
         end
         tick();
         for (int i = 0; i < 2; i++) wr_in[i] = wr_in[i] & ~acc[i];
      end
      for (int i = 0; i < 2; i++) begin
         check("rand_drops", obs_drops[i], exp_drops[i]);
         check("rand_inputs_idle", wr_in[i], 0);
         for (int q = 0; q < NP*NP; q++)
            check("rand_drained", exp_q[i*NP*NP + q].size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
